// File: rtl/tlp_xcvr_pkg.sv
// Shared types and defaults for the TLP transceiver, including the FPGA-to-host (F2C) packing path.
package tlp_xcvr_pkg;

    typedef logic [63:0] uint64;
    typedef logic [31:0] uint32;

    // 32 qwords holds two full 16-qword F2C TLPs.
    localparam int F2C_FIFO_DEPTH_NBITS = 5;

    function automatic uint64 packQword(input uint32 lowWord, input uint32 highWord);
        return {highWord, lowWord};
    endfunction

endpackage

// File: rtl/f2c_fifo.sv
// First-word-fall-through qword FIFO with occupancy count and synchronous flush.
module f2c_fifo
    import tlp_xcvr_pkg::*;
#(
    parameter int DEPTH_NBITS = F2C_FIFO_DEPTH_NBITS
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 flush_in,
    input  logic                 wrEn_i,
    input  uint64                wrData_i,
    input  logic                 rdEn_i,
    output uint64                rdData_o,
    output logic [DEPTH_NBITS:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam logic [DEPTH_NBITS-1:0] PTR_ONE    = DEPTH_NBITS'(1);
    localparam logic [DEPTH_NBITS:0]   COUNT_ONE  = (DEPTH_NBITS + 1)'(1);
    localparam logic [DEPTH_NBITS:0]   FULL_COUNT = (DEPTH_NBITS + 1)'(DEPTH);

    uint64                  mem_q [DEPTH];
    logic [DEPTH_NBITS-1:0] wrPtr_q;
    logic [DEPTH_NBITS-1:0] wrPtr_d;
    logic [DEPTH_NBITS-1:0] rdPtr_q;
    logic [DEPTH_NBITS-1:0] rdPtr_d;
    logic [DEPTH_NBITS:0]   count_q;
    logic [DEPTH_NBITS:0]   count_d;
    logic                   doWrite;
    logic                   doRead;

    assign full_o   = (count_q == FULL_COUNT);
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rdData_o = mem_q[rdPtr_q];

    // Flush beats both ports; the full/empty guards rule out overflow and underflow.
    assign doWrite = wrEn_i && !full_o && !flush_in;
    assign doRead  = rdEn_i && !empty_o && !flush_in;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_in) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (doRead) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (doWrite && !doRead) begin
                count_d = count_q + COUNT_ONE;
            end else if (doRead && !doWrite) begin
                count_d = count_q - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; entries are only visible once written.
    always_ff @(posedge clk_in) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/f2c_packer.sv
// Packs pairs of 32-bit application words into 64-bit qwords (first word low) and
// buffers them in an FWFT FIFO feeding the transceiver's f2cData/f2cValid/f2cReady.
module f2c_packer
    import tlp_xcvr_pkg::*;
#(
    parameter int DEPTH_NBITS = F2C_FIFO_DEPTH_NBITS
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 flush_in,
    input  logic [31:0]          data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output uint64                data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [DEPTH_NBITS:0] count_out
);

    logic        lowHeld_q;
    logic        lowHeld_d;
    logic [31:0] holdWord_q;
    logic [31:0] holdWord_d;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        wordAccept;
    logic        qwordWrite;
    logic        qwordRead;
    uint64       packedQword;

    // A low word can always be parked; only a high word needs FIFO room.
    // Kept independent of ready_in so a full FIFO is never written even on a same-edge read.
    assign ready_out   = !reset_in && !flush_in && (!lowHeld_q || !fifoFull);
    assign wordAccept  = valid_in && ready_out;
    assign qwordWrite  = wordAccept && lowHeld_q;
    assign valid_out   = !fifoEmpty;
    assign qwordRead   = valid_out && ready_in;
    assign packedQword = packQword(holdWord_q, data_in);

    always_comb begin
        lowHeld_d  = lowHeld_q;
        holdWord_d = holdWord_q;
        if (flush_in) begin
            lowHeld_d = 1'b0;
        end else if (wordAccept) begin
            if (lowHeld_q) begin
                lowHeld_d = 1'b0;
            end else begin
                lowHeld_d  = 1'b1;
                holdWord_d = data_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lowHeld_q  <= 1'b0;
            holdWord_q <= '0;
        end else begin
            lowHeld_q  <= lowHeld_d;
            holdWord_q <= holdWord_d;
        end
    end

    f2c_fifo #(
        .DEPTH_NBITS (DEPTH_NBITS)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .flush_in (flush_in),
        .wrEn_i   (qwordWrite),
        .wrData_i (packedQword),
        .rdEn_i   (qwordRead),
        .rdData_o (data_out),
        .count_o  (count_out),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

endmodule

// File: tb/tb_f2c_packer.sv
// Directed bench for f2c_packer: packing, latency, backpressure, pointer wrap,
// randomly gapped streaming, flush and mid-stream reset.
module tb_f2c_packer;
    import tlp_xcvr_pkg::*;

    localparam int TB_DEPTH_NBITS = F2C_FIFO_DEPTH_NBITS;

    logic                    clk_in;
    logic                    reset_in;
    logic                    flush_in;
    logic [31:0]             data_in;
    logic                    valid_in;
    logic                    ready_out;
    uint64                   data_out;
    logic                    valid_out;
    logic                    ready_in;
    logic [TB_DEPTH_NBITS:0] count_out;

    int    passCount  = 0;
    int    failCount  = 0;
    int    checkCount = 0;
    logic  wordTaken;
    logic  qwordTaken;
    logic  readyObserved;
    uint64 qwordObserved;
    uint64 expQ[$];
    logic  modelLowHeld;
    logic [31:0] modelLowWord;

    f2c_packer #(
        .DEPTH_NBITS (TB_DEPTH_NBITS)
    ) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .flush_in  (flush_in),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .count_out (count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] seq32(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic uint64 seq64(input int k);
        return {seq32(2 * k + 1), seq32(2 * k)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, records both handshakes just before the edge,
    // updates the packing model and scoreboard, and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                                 input logic fl, input logic rst);
        uint64 expQword;
        valid_in = v;
        data_in  = d;
        ready_in = rdy;
        flush_in = fl;
        reset_in = rst;
        #1;
        readyObserved = ready_out;
        wordTaken     = valid_in && ready_out;
        qwordTaken    = valid_out && ready_in;
        qwordObserved = data_out;
        if (rst || fl) begin
            expQ.delete();
            modelLowHeld = 1'b0;
            wordTaken    = 1'b0;
            qwordTaken   = 1'b0;
        end else begin
            if (qwordTaken) begin
                if (expQ.size() != 0) expQword = expQ.pop_front();
                else expQword = ~qwordObserved;
                checkOutput("qword_order", qwordObserved, expQword);
            end
            if (wordTaken) begin
                if (modelLowHeld) begin
                    expQ.push_back({d, modelLowWord});
                    modelLowHeld = 1'b0;
                end else begin
                    modelLowWord = d;
                    modelLowHeld = 1'b1;
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int   accepted;
        int   reads;
        int   idx;
        logic v;
        valid_in     = 1'b0;
        data_in      = '0;
        ready_in     = 1'b0;
        flush_in     = 1'b0;
        reset_in     = 1'b1;
        modelLowHeld = 1'b0;
        modelLowWord = '0;

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset_ready_low", readyObserved, 0);
        checkOutput("reset_count", count_out, 0);
        checkOutput("reset_valid", valid_out, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ready_after_reset", readyObserved, 1);

        applyStimulus(1, 32'h1111_1111, 1, 0, 0);
        checkOutput("first_word_taken", wordTaken, 1);
        checkOutput("valid_after_low", valid_out, 0);
        applyStimulus(1, 32'h2222_2222, 1, 0, 0);
        checkOutput("valid_latency", valid_out, 1);
        checkOutput("first_qword", data_out, 64'h2222_2222_1111_1111);
        checkOutput("count_one", count_out, 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("first_drained", count_out, 0);

        accepted = 0;
        for (int i = 0; i < 65; i++) begin
            applyStimulus(1, 32'hA000_0000 + 32'(i), 0, 0, 0);
            if (wordTaken) accepted++;
        end
        checkOutput("backpressure_accepted", accepted, 65);
        checkOutput("backpressure_count", count_out, 32);
        checkOutput("backpressure_ready_low", ready_out, 0);
        idx   = 65;
        reads = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(idx < 70, 32'hA000_0000 + 32'(idx), 1, 0, 0);
            if (wordTaken) idx++;
            if (qwordTaken && c < 32) reads++;
            if (idx == 70 && count_out == 0) break;
        end
        checkOutput("back_to_back_reads", reads, 32);
        checkOutput("backpressure_all_words", idx, 70);
        checkOutput("backpressure_no_loss", expQ.size(), 0);

        for (int f = 0; f < 3; f++) begin
            accepted = 0;
            for (int i = 0; i < 64; i++) begin
                applyStimulus(1, 32'hB000_0000 + 32'(f * 256 + i), 0, 0, 0);
                if (wordTaken) accepted++;
            end
            checkOutput("wrap_fill_accepted", accepted, 64);
            checkOutput("wrap_fill_count", count_out, 32);
            reads = 0;
            for (int c = 0; c < 32; c++) begin
                applyStimulus(0, 0, 1, 0, 0);
                if (qwordTaken) reads++;
            end
            checkOutput("wrap_drain_reads", reads, 32);
            checkOutput("wrap_drain_count", count_out, 0);
        end

        idx   = 0;
        reads = 0;
        for (int c = 0; c < 3000 && (idx < 256 || count_out != 0); c++) begin
            v = (idx < 256) && ($urandom_range(0, 3) != 0);
            applyStimulus(v, seq32(idx), $urandom_range(0, 3) != 0, 0, 0);
            if (wordTaken) idx++;
            if (qwordTaken) begin
                checkOutput("seq64", qwordObserved, seq64(reads));
                reads++;
            end
        end
        checkOutput("seq_words", idx, 256);
        checkOutput("seq_qwords", reads, 128);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'hF000_0000 + 32'(i), 0, 0, 0);
        end
        checkOutput("preflush_count", count_out, 2);
        applyStimulus(1, 32'hDEAD_BEEF, 1, 1, 0);
        checkOutput("flush_ready_low", readyObserved, 0);
        checkOutput("flush_count", count_out, 0);
        checkOutput("flush_valid", valid_out, 0);
        applyStimulus(1, 32'h3333_3333, 0, 0, 0);
        applyStimulus(1, 32'h4444_4444, 0, 0, 0);
        checkOutput("postflush_count", count_out, 1);
        checkOutput("postflush_qword", data_out, 64'h4444_4444_3333_3333);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("postflush_drained", count_out, 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 32'hC000_0000 + 32'(i), 0, 0, 0);
        end
        checkOutput("prereset_count", count_out, 10);
        applyStimulus(1, 32'h5555_5555, 1, 0, 1);
        checkOutput("midreset_ready_low", readyObserved, 0);
        checkOutput("midreset_count", count_out, 0);
        checkOutput("midreset_valid", valid_out, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ready_after_midreset", readyObserved, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
